// File: rtl/fft_bfly_r2_pipe.sv
// Pipelined radix-2 DIT butterfly: y0 = a + w*b, y1 = a - w*b in signed Q(INT_W.FRAC_W),
// three register stages with valid/ready flow control, optional /2 scaling and saturation.
module fft_bfly_r2_pipe #(
  parameter int INT_W  = 8,
  parameter int FRAC_W = 8,
  parameter int SAT_EN = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_scale,
  input  logic [INT_W+FRAC_W-1:0]   a_re,
  input  logic [INT_W+FRAC_W-1:0]   a_im,
  input  logic [INT_W+FRAC_W-1:0]   b_re,
  input  logic [INT_W+FRAC_W-1:0]   b_im,
  input  logic [INT_W+FRAC_W-1:0]   w_re,
  input  logic [INT_W+FRAC_W-1:0]   w_im,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INT_W+FRAC_W-1:0]   y0_re,
  output logic [INT_W+FRAC_W-1:0]   y0_im,
  output logic [INT_W+FRAC_W-1:0]   y1_re,
  output logic [INT_W+FRAC_W-1:0]   y1_im,
  output logic                      ovf,
  output logic                      ovf_sticky,
  input  logic                      sticky_clr
);

  localparam int W  = INT_W + FRAC_W;
  localparam int PW = 2 * W;
  localparam int SW = W + 3;
  localparam logic signed [PW:0] RND = (PW+1)'((2 ** FRAC_W) / 2);

  // stage 1: operand a, scale flag and the four partial products
  logic                 v1_q, v1_d, sc1_q, sc1_d;
  logic signed [W-1:0]  ar1_q, ar1_d, ai1_q, ai1_d;
  logic signed [PW-1:0] prr_q, prr_d, pii_q, pii_d, pri_q, pri_d, pir_q, pir_d;

  // stage 2: unscaled sums/differences
  logic                 v2_q, v2_d, sc2_q, sc2_d;
  logic signed [SW-1:0] s0r_q, s0r_d, s0i_q, s0i_d, s1r_q, s1r_d, s1i_q, s1i_d;

  // stage 3: output register
  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         y0r_q, y0r_d, y0i_q, y0i_d, y1r_q, y1r_d, y1i_q, y1i_d;
  logic                 ovf_q, ovf_d, sticky_q, sticky_d;

  logic                 ld1, ld2, ld3;
  logic signed [PW:0]   pr_full, pi_full;
  logic signed [SW-1:0] pr_t, pi_t;
  logic [W:0]           l0r, l0i, l1r, l1i;

  // {ovf, y}: optional round-half-up halving, then clip or wrap to W bits
  function automatic logic [W:0] finish_lane(input logic signed [SW-1:0] s,
                                             input logic scale);
    logic signed [SW:0] t;
    logic               fits;
    logic [W-1:0]       y;
    t = (SW+1)'(s);
    if (scale) t = (t + (SW+1)'(1)) >>> 1;
    fits = (t[SW:W-1] == '0) || (t[SW:W-1] == '1);
    if (fits || SAT_EN == 0) y = t[W-1:0];
    else if (t[SW])          y = {1'b1, {(W-1){1'b0}}};
    else                     y = {1'b0, {(W-1){1'b1}}};
    return {!fits, y};
  endfunction

  // each stage may advance into a slot that is empty or being vacated this cycle
  always_comb begin
    ld3 = !out_valid_q || out_ready;
    ld2 = !v2_q || ld3;
    ld1 = !v1_q || ld2;
  end

  always_comb begin
    v1_d  = v1_q;
    sc1_d = sc1_q;
    ar1_d = ar1_q;
    ai1_d = ai1_q;
    prr_d = prr_q;
    pii_d = pii_q;
    pri_d = pri_q;
    pir_d = pir_q;
    if (ld1) begin
      v1_d = in_valid;
      if (in_valid) begin
        sc1_d = in_scale;
        ar1_d = a_re;
        ai1_d = a_im;
        prr_d = PW'($signed(b_re)) * PW'($signed(w_re));
        pii_d = PW'($signed(b_im)) * PW'($signed(w_im));
        pri_d = PW'($signed(b_re)) * PW'($signed(w_im));
        pir_d = PW'($signed(b_im)) * PW'($signed(w_re));
      end
    end
  end

  always_comb begin
    pr_full = (PW+1)'(prr_q) - (PW+1)'(pii_q);
    pi_full = (PW+1)'(pri_q) + (PW+1)'(pir_q);
    pr_t    = SW'((pr_full + RND) >>> FRAC_W);
    pi_t    = SW'((pi_full + RND) >>> FRAC_W);
    v2_d    = v2_q;
    sc2_d   = sc2_q;
    s0r_d   = s0r_q;
    s0i_d   = s0i_q;
    s1r_d   = s1r_q;
    s1i_d   = s1i_q;
    if (ld2) begin
      v2_d = v1_q;
      if (v1_q) begin
        sc2_d = sc1_q;
        s0r_d = SW'(ar1_q) + pr_t;
        s0i_d = SW'(ai1_q) + pi_t;
        s1r_d = SW'(ar1_q) - pr_t;
        s1i_d = SW'(ai1_q) - pi_t;
      end
    end
  end

  always_comb begin
    l0r         = finish_lane(s0r_q, sc2_q);
    l0i         = finish_lane(s0i_q, sc2_q);
    l1r         = finish_lane(s1r_q, sc2_q);
    l1i         = finish_lane(s1i_q, sc2_q);
    out_valid_d = out_valid_q;
    y0r_d       = y0r_q;
    y0i_d       = y0i_q;
    y1r_d       = y1r_q;
    y1i_d       = y1i_q;
    ovf_d       = ovf_q;
    if (ld3) begin
      out_valid_d = v2_q;
      ovf_d       = 1'b0;
      if (v2_q) begin
        y0r_d = l0r[W-1:0];
        y0i_d = l0i[W-1:0];
        y1r_d = l1r[W-1:0];
        y1i_d = l1i[W-1:0];
        ovf_d = l0r[W] | l0i[W] | l1r[W] | l1i[W];
      end
    end
    // a set from a transferring overflow beat beats a simultaneous clear
    sticky_d = (sticky_q && !sticky_clr) || (out_valid_q && out_ready && ovf_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      sc1_q       <= 1'b0;
      ar1_q       <= '0;
      ai1_q       <= '0;
      prr_q       <= '0;
      pii_q       <= '0;
      pri_q       <= '0;
      pir_q       <= '0;
      v2_q        <= 1'b0;
      sc2_q       <= 1'b0;
      s0r_q       <= '0;
      s0i_q       <= '0;
      s1r_q       <= '0;
      s1i_q       <= '0;
      out_valid_q <= 1'b0;
      y0r_q       <= '0;
      y0i_q       <= '0;
      y1r_q       <= '0;
      y1i_q       <= '0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      sc1_q       <= sc1_d;
      ar1_q       <= ar1_d;
      ai1_q       <= ai1_d;
      prr_q       <= prr_d;
      pii_q       <= pii_d;
      pri_q       <= pri_d;
      pir_q       <= pir_d;
      v2_q        <= v2_d;
      sc2_q       <= sc2_d;
      s0r_q       <= s0r_d;
      s0i_q       <= s0i_d;
      s1r_q       <= s1r_d;
      s1i_q       <= s1i_d;
      out_valid_q <= out_valid_d;
      y0r_q       <= y0r_d;
      y0i_q       <= y0i_d;
      y1r_q       <= y1r_d;
      y1i_q       <= y1i_d;
      ovf_q       <= ovf_d;
      sticky_q    <= sticky_d;
    end
  end

  assign in_ready   = ld1;
  assign out_valid  = out_valid_q;
  assign y0_re      = y0r_q;
  assign y0_im      = y0i_q;
  assign y1_re      = y1r_q;
  assign y1_im      = y1i_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_fft_bfly_r2_pipe.sv
// Bench for fft_bfly_r2_pipe: saturating and wrapping instances share stimulus; results are
// checked against an integer reference model through an in-order scoreboard.
module tb_fft_bfly_r2_pipe;
  localparam int INT_W = 8;
  localparam int FRAC_W = 8;
  localparam int W = INT_W + FRAC_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_scale, out_ready, sticky_clr;
  logic [W-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic in_ready_s, out_valid_s, ovf_s, ovf_sticky_s;
  logic in_ready_w, out_valid_w, ovf_w, ovf_sticky_w;
  logic [W-1:0] y0_re_s, y0_im_s, y1_re_s, y1_im_s;
  logic [W-1:0] y0_re_w, y0_im_w, y1_re_w, y1_im_w;

  fft_bfly_r2_pipe #(.INT_W(INT_W), .FRAC_W(FRAC_W), .SAT_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_scale(in_scale),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .y0_re(y0_re_s), .y0_im(y0_im_s), .y1_re(y1_re_s), .y1_im(y1_im_s),
    .ovf(ovf_s), .ovf_sticky(ovf_sticky_s), .sticky_clr(sticky_clr));

  fft_bfly_r2_pipe #(.INT_W(INT_W), .FRAC_W(FRAC_W), .SAT_EN(0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_scale(in_scale),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .y0_re(y0_re_w), .y0_im(y0_im_w), .y1_re(y1_re_w), .y1_im(y1_im_w),
    .ovf(ovf_w), .ovf_sticky(ovf_sticky_w), .sticky_clr(sticky_clr));

  typedef struct {
    logic [64:0] sat;
    logic [64:0] wrp;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_mis = 0;
  int n_deliv = 0;
  bit hold = 0, st_s = 0, st_w = 0;
  bit last_in_x = 0, last_out_x = 0, last_rdy = 0;
  logic [65:0] hold_s, hold_w;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic longint floordiv(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && ((n < 0) != (d < 0))) q -= 1;
    return q;
  endfunction

  function automatic longint wrapto(input longint v, input int n);
    longint m, r;
    m = longint'(1) << n;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  // {y0_re, y0_im, y1_re, y1_im, ovf} from plain integer arithmetic
  function automatic logic [64:0] model(input logic [W-1:0] ar, ai, br, bi, wr, wi,
                                        input bit sc, input bit sat);
    longint xr, xi, pr, pi, v;
    longint s[4];
    logic [W-1:0] y[4];
    bit ov;
    xr = longint'($signed(br));
    xi = longint'($signed(bi));
    pr = floordiv(xr * longint'($signed(wr)) - xi * longint'($signed(wi)) + 128, 256);
    pi = floordiv(xr * longint'($signed(wi)) + xi * longint'($signed(wr)) + 128, 256);
    s[0] = longint'($signed(ar)) + pr;
    s[1] = longint'($signed(ai)) + pi;
    s[2] = longint'($signed(ar)) - pr;
    s[3] = longint'($signed(ai)) - pi;
    ov = 0;
    for (int k = 0; k < 4; k++) begin
      v = wrapto(s[k], W + 3);
      if (sc) v = floordiv(v + 1, 2);
      if (v > 32767 || v < -32768) begin
        ov = 1;
        if (sat) v = (v > 0) ? 32767 : -32768;
        else     v = wrapto(v, W);
      end
      y[k] = W'(v);
    end
    return {y[0], y[1], y[2], y[3], ov};
  endfunction

  // one clock: checks at the settled point, scoreboard bookkeeping, then the edge
  task automatic cyc();
    exp_t e;
    logic [64:0] os, ow;
    bit in_x, out_x, clr, rs, set_s, set_w;
    #1;
    os = {y0_re_s, y0_im_s, y1_re_s, y1_im_s, ovf_s};
    ow = {y0_re_w, y0_im_w, y1_re_w, y1_im_w, ovf_w};
    rs = rst;
    last_rdy = in_ready_s;
    if (!rs) begin
      check("in_ready_s", 80'(in_ready_s), 80'(!(sb.size() == 3 && !out_ready)));
      check("in_ready_w", 80'(in_ready_w), 80'(!(sb.size() == 3 && !out_ready)));
      if (sb.size() == 0) check("no_spurious_valid", 80'(out_valid_s), 80'(1'b0));
      if (hold) begin
        check("stall_hold_s", 80'({out_valid_s, os}), 80'(hold_s));
        check("stall_hold_w", 80'({out_valid_w, ow}), 80'(hold_w));
      end
    end
    in_x  = in_valid && in_ready_s && !rs;
    out_x = out_valid_s && out_ready && !rs;
    hold  = out_valid_s && !out_ready && !rs;
    hold_s = {out_valid_s, os};
    hold_w = {out_valid_w, ow};
    clr = sticky_clr;
    set_s = 0;
    set_w = 0;
    last_in_x = in_x;
    last_out_x = out_x;
    if (out_x && sb.size() > 0) begin
      e = sb.pop_front();
      n_deliv++;
      check("beat_sat", 80'(os), 80'(e.sat));
      check("beat_wrap", 80'(ow), 80'(e.wrp));
      set_s = e.sat[0];
      set_w = e.wrp[0];
    end
    if (in_x) begin
      e.sat = model(a_re, a_im, b_re, b_im, w_re, w_im, in_scale, 1'b1);
      e.wrp = model(a_re, a_im, b_re, b_im, w_re, w_im, in_scale, 1'b0);
      sb.push_back(e);
    end
    @(posedge clk);
    if (rs) begin
      sb.delete();
      hold = 0;
      st_s = 0;
      st_w = 0;
    end else begin
      if (clr) begin
        st_s = 0;
        st_w = 0;
      end
      if (set_s) st_s = 1;
      if (set_w) st_w = 1;
    end
    #1;
    check("sticky_s", 80'(ovf_sticky_s), 80'(st_s));
    check("sticky_w", 80'(ovf_sticky_w), 80'(st_w));
  endtask

  // single beat into an empty pipe, returns once out_valid is seen (result still held)
  task automatic beat(input logic [W-1:0] ar, ai, br, bi, wr, wi, input bit sc);
    int n;
    a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
    in_scale = sc;
    in_valid = 1;
    out_ready = 1;
    cyc();
    check("accepted", 80'(last_in_x), 80'(1'b1));
    in_valid = 0;
    n = 1;
    while (!out_valid_s && n < 12) begin
      cyc();
      n++;
    end
    check("latency", 80'(n), 80'(3));
  endtask

  function automatic logic [W-1:0] rval(input int unsigned span);
    if (span == 0) return W'($urandom);
    return W'($urandom_range(0, 2 * span)) - W'(span);
  endfunction

  task automatic rand_operands();
    int unsigned m, ws, osp;
    m = $urandom_range(0, 2);
    ws = (m == 2) ? 0 : 256;
    osp = (m == 1) ? 1024 : 0;
    a_re = rval(osp); a_im = rval(osp);
    b_re = rval(osp); b_im = rval(osp);
    w_re = rval(ws);  w_im = rval(ws);
    in_scale = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, base, held;
    bit fell, need_new;
    rst = 1; in_valid = 0; in_scale = 0; out_ready = 1; sticky_clr = 0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
    cyc();
    cyc();
    rst = 0;
    check("rst_out_valid", 80'(out_valid_s), 80'(1'b0));
    check("rst_y", 80'({y0_re_s, y0_im_s, y1_re_s, y1_im_s}), 80'(0));
    check("rst_ovf", 80'(ovf_s), 80'(1'b0));
    check("rst_in_ready", 80'(in_ready_s), 80'(1'b1));

    // 1: unity inputs
    beat(16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 0);
    check("t1_y0", 80'({y0_re_s, y0_im_s}), 80'({16'h0200, 16'h0000}));
    check("t1_y1", 80'({y1_re_s, y1_im_s}), 80'({16'h0000, 16'h0000}));
    check("t1_ovf", 80'(ovf_s), 80'(1'b0));
    cyc();

    // 2: 45-degree twiddle
    beat(16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h00B5, 16'hFF4B, 0);
    check("t2_y0", 80'({y0_re_s, y0_im_s}), 80'({16'h00B5, 16'hFF4B}));
    check("t2_y1", 80'({y1_re_s, y1_im_s}), 80'({16'hFF4B, 16'h00B5}));
    cyc();

    // 3: rounding of the product
    beat(16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0080, 16'h0000, 0);
    check("t3_round_up", 80'({y0_re_s, y1_re_s}), 80'({16'h0001, 16'hFFFF}));
    cyc();
    beat(16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 0);
    check("t3_half_up", 80'({y0_re_s, y1_re_s}), 80'({16'h0000, 16'h0000}));
    cyc();

    // 4: overflow, saturation vs wrap, sticky behaviour
    beat(16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 16'h0100, 16'h0000, 0);
    check("t4_sat_y0", 80'(y0_re_s), 80'(16'h7FFF));
    check("t4_sat_y1", 80'(y1_re_s), 80'(16'h0000));
    check("t4_sat_ovf", 80'(ovf_s), 80'(1'b1));
    check("t4_wrap_y0", 80'(y0_re_w), 80'(16'hFE00));
    check("t4_wrap_ovf", 80'(ovf_w), 80'(1'b1));
    check("t4_sticky_pre", 80'(ovf_sticky_s), 80'(1'b0));
    sticky_clr = 1;
    cyc();
    sticky_clr = 0;
    check("t4_set_wins", 80'(ovf_sticky_s), 80'(1'b1));
    beat(16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 16'h0100, 16'h0000, 1);
    check("t4_scaled_y0", 80'(y0_re_s), 80'(16'h7F00));
    check("t4_scaled_ovf", 80'(ovf_s), 80'(1'b0));
    cyc();
    check("t4_sticky_held", 80'(ovf_sticky_s), 80'(1'b1));
    sticky_clr = 1;
    cyc();
    sticky_clr = 0;
    check("t4_sticky_clr", 80'(ovf_sticky_s), 80'(1'b0));

    // 5: 8-beat stream with out_ready low in cycles 4..9
    sent = 0; fell = 0; need_new = 1; base = n_deliv;
    for (int c = 0; c < 40 && (sent < 8 || sb.size() > 0); c++) begin
      in_valid = (sent < 8);
      if (in_valid && need_new) rand_operands();
      out_ready = !(c >= 4 && c <= 9);
      cyc();
      if (!last_rdy) fell = 1;
      if (last_in_x) sent++;
      need_new = last_in_x;
    end
    in_valid = 0;
    out_ready = 1;
    check("t5_in_ready_fell", 80'(fell), 80'(1'b1));
    check("t5_delivered", 80'(n_deliv - base), 80'(8));

    // 6: reset with three beats in flight
    out_ready = 0;
    held = 0;
    for (int c = 0; c < 6 && held < 3; c++) begin
      in_valid = 1;
      rand_operands();
      cyc();
      if (last_in_x) held++;
    end
    in_valid = 0;
    check("t6_held", 80'(held), 80'(3));
    rst = 1;
    cyc();
    rst = 0;
    check("t6_out_valid", 80'(out_valid_s), 80'(1'b0));
    check("t6_y", 80'({y0_re_s, y0_im_s, y1_re_s, y1_im_s}), 80'(0));
    check("t6_in_ready", 80'(in_ready_s), 80'(1'b1));
    beat(16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 0);
    check("t6_fresh_y0", 80'({y0_re_s, y0_im_s}), 80'({16'h0200, 16'h0000}));
    cyc();

    // randomized traffic with random backpressure and sticky clears
    need_new = 1;
    for (int c = 0; c < 500; c++) begin
      if (!in_valid || last_in_x) begin
        in_valid = ($urandom_range(0, 9) < 7);
        rand_operands();
      end
      out_ready = ($urandom_range(0, 9) < 7);
      sticky_clr = ($urandom_range(0, 19) == 0);
      cyc();
    end
    in_valid = 0;
    sticky_clr = 0;
    out_ready = 1;
    for (int c = 0; c < 10 && sb.size() > 0; c++) cyc();
    check("drain_empty", 80'(sb.size()), 80'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
